// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner of the shared MESI snoop bus: grant, broadcast, snoop collection, write-back, completion.
// Optional write-back watchdog enabled by defining BUS_ARB_WB_TIMEOUT_EN.
module coherence_bus_arbiter #(
    parameter int NUM_CORE   = 4,
    parameter int ADDR_W     = 32,
    parameter int WB_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORE-1:0]           req_valid,
    input  logic [2*NUM_CORE-1:0]         req_type,
    input  logic [ADDR_W*NUM_CORE-1:0]    req_addr,
    output logic [NUM_CORE-1:0]           grant,
    output logic [1:0]                    bus_req,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [$clog2(NUM_CORE)-1:0]   bus_src,
    input  logic [2*NUM_CORE-1:0]         snoop_rsp,
    input  logic [NUM_CORE-1:0]           snoop_wb,
    output logic                          mem_wb_req,
    input  logic                          mem_wb_ack,
    output logic [NUM_CORE-1:0]           done,
    output logic                          done_found,
    output logic                          err
);

    localparam int SRC_W = $clog2(NUM_CORE);

    localparam logic [1:0] BUS_NO_REQ          = 2'b00;
    localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'b01;

    if (NUM_CORE < 2 || WB_TIMEOUT < 2) begin : g_bad_param
        $error("coherence_bus_arbiter: NUM_CORE and WB_TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        WB    = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [SRC_W-1:0]   src_q;
    logic [SRC_W-1:0]   rr_ptr;
    logic [1:0]         type_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               found_q;

    logic               arb_hit;
    logic [SRC_W-1:0]   arb_idx;
    logic [NUM_CORE-1:0] wb_masked;
    logic [NUM_CORE-1:0] found_lane;
    logic               multi_wb;
    logic               wb_timeout;

    // Scan from the highest offset down so the lane closest to rr_ptr wins.
    always_comb begin
        int idx;
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORE) begin
                idx = idx - NUM_CORE;
            end
            if (req_valid[idx] && (req_type[2*idx +: 2] != BUS_NO_REQ)) begin
                arb_hit = 1'b1;
                arb_idx = SRC_W'(idx);
            end
        end
    end

    // The requester's own snoop lane never counts toward found or write-back.
    always_comb begin
        wb_masked  = '0;
        found_lane = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (SRC_W'(i) != src_q) begin
                wb_masked[i]  = snoop_wb[i];
                found_lane[i] = (snoop_rsp[2*i +: 2] == BUS_SNOOP_FOUND_RSP);
            end
        end
    end

    assign multi_wb = ((wb_masked & (wb_masked - 1'b1)) != '0);

`ifdef BUS_ARB_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(WB_TIMEOUT + 1);

    logic [CNT_W-1:0] wb_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WB) begin
            wb_cnt <= '0;
        end else begin
            wb_cnt <= wb_cnt + 1'b1;
        end
    end

    assign wb_timeout = (state == WB) && !mem_wb_ack &&
                        (wb_cnt == CNT_W'(WB_TIMEOUT - 1));
`else
    assign wb_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            rr_ptr  <= '0;
            type_q  <= BUS_NO_REQ;
            addr_q  <= '0;
            found_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        src_q  <= arb_idx;
                        type_q <= req_type[2*int'(arb_idx) +: 2];
                        addr_q <= req_addr[ADDR_W*int'(arb_idx) +: ADDR_W];
                    end
                end
                BCAST: begin
                    found_q <= |found_lane;
                end
                DONE: begin
                    rr_ptr <= (src_q == SRC_W'(NUM_CORE - 1)) ? '0 : src_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (arb_hit) next_state = BCAST;
            BCAST:   next_state = (wb_masked != '0) ? WB : DONE;
            WB:      if (mem_wb_ack || wb_timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant      = '0;
        done       = '0;
        done_found = 1'b0;
        bus_req    = BUS_NO_REQ;
        mem_wb_req = 1'b0;
        err        = 1'b0;
        if (state != IDLE) begin
            grant[src_q] = 1'b1;
        end
        case (state)
            BCAST: begin
                bus_req = type_q;
                err     = multi_wb;
            end
            WB: begin
                mem_wb_req = 1'b1;
                err        = wb_timeout;
            end
            DONE: begin
                done[src_q] = 1'b1;
                done_found  = found_q;
            end
            default: begin
            end
        endcase
    end

    assign bus_addr = addr_q;
    assign bus_src  = src_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed and randomized transactions against a transaction-level round-robin reference model.
module tb_coherence_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;

    localparam logic [1:0] NO_REQ = 2'b00;
    localparam logic [1:0] RD     = 2'b01;
    localparam logic [1:0] RWITM  = 2'b10;
    localparam logic [1:0] FOUND  = 2'b01;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_type;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    grant;
    logic [1:0]      bus_req;
    logic [AW-1:0]   bus_addr;
    logic [1:0]      bus_src;
    logic [2*N-1:0]  snoop_rsp;
    logic [N-1:0]    snoop_wb;
    logic            mem_wb_req;
    logic            mem_wb_ack;
    logic [N-1:0]    done;
    logic            done_found;
    logic            err;

    int checks = 0;
    int errors = 0;
    int rr     = 0;

    coherence_bus_arbiter #(.NUM_CORE(N), .ADDR_W(AW), .WB_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .grant      (grant),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_src    (bus_src),
        .snoop_rsp  (snoop_rsp),
        .snoop_wb   (snoop_wb),
        .mem_wb_req (mem_wb_req),
        .mem_wb_ack (mem_wb_ack),
        .done       (done),
        .done_found (done_found),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Winner is the requesting core with the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] v, input logic [2*N-1:0] t, input int r);
        int best  = -1;
        int bestd = N;
        for (int c = 0; c < N; c++) begin
            if (v[c] && t[2*c +: 2] != NO_REQ) begin
                int d = (c - r + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = c;
                end
            end
        end
        return best;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_bus_req"}, bus_req, NO_REQ);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_src"}, bus_src, 0);
        chk({tag, "_mem_wb_req"}, mem_wb_req, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_found"}, done_found, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Starts in an IDLE cycle just after a falling edge; ends in the IDLE cycle after DONE.
    task automatic do_txn(input logic [N-1:0] v, input logic [2*N-1:0] t, input logic [AW*N-1:0] a,
                          input logic [2*N-1:0] rsp, input logic [N-1:0] wb, input int wbwait,
                          input logic [N-1:0] v_after, output int src_seen);
        int           w;
        logic [N-1:0] oh;
        logic [N-1:0] mwb;
        logic         found;
        req_valid  = v;
        req_type   = t;
        req_addr   = a;
        snoop_rsp  = '0;
        snoop_wb   = '0;
        mem_wb_ack = 1'b0;
        w          = pick(v, t, rr);
        src_seen   = -1;
        #1;
        chk("idle_grant", grant, 0);
        step();
        if (w < 0) begin
            chk("nogrant_grant", grant, 0);
            chk("nogrant_bus_req", bus_req, NO_REQ);
            return;
        end
        oh       = N'(1) << w;
        src_seen = int'(bus_src);
        chk("bcast_grant", grant, oh);
        chk("bcast_src", bus_src, w);
        chk("bcast_req", bus_req, t[2*w +: 2]);
        chk("bcast_addr", bus_addr, a[AW*w +: AW]);
        req_valid = v_after;
        snoop_rsp = rsp;
        snoop_wb  = wb;
        #1;
        mwb   = wb & ~oh;
        found = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (c != w && rsp[2*c +: 2] == FOUND) found = 1'b1;
        end
        chk("bcast_err", err, $countones(mwb) > 1);
        chk("bcast_done", done, 0);
        chk("bcast_wb_req", mem_wb_req, 0);
        step();
        snoop_rsp = '0;
        snoop_wb  = '0;
        if (mwb != '0) begin
            for (int k = 0; k < wbwait; k++) begin
                chk("wb_req", mem_wb_req, 1);
                chk("wb_bus_req", bus_req, NO_REQ);
                chk("wb_grant", grant, oh);
                chk("wb_done", done, 0);
                step();
            end
            mem_wb_ack = 1'b1;
            #1;
            chk("wb_ack_req", mem_wb_req, 1);
            step();
            mem_wb_ack = 1'b0;
        end
        chk("done_vec", done, oh);
        chk("done_found", done_found, found);
        chk("done_grant", grant, oh);
        chk("done_bus_req", bus_req, NO_REQ);
        chk("done_wb_req", mem_wb_req, 0);
        rr = (w + 1) % N;
        step();
        chk("post_done", done, 0);
        chk("post_grant", grant, 0);
    endtask

    initial begin
        int s;
        logic [AW*N-1:0] ra;
        rst        = 1'b1;
        req_valid  = '0;
        req_type   = '0;
        req_addr   = '0;
        snoop_rsp  = '0;
        snoop_wb   = '0;
        mem_wb_ack = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Core1 READ of 0x40, no snoop hits.
        do_txn(4'b0010, {NO_REQ, NO_REQ, RD, NO_REQ}, {32'h0, 32'h0, 32'h40, 32'h0},
               '0, '0, 0, 4'b0010, s);
        chk("t1_src", s, 1);

        // Core0 RWITM, core2 FOUND with write-back; ack after 3 WB cycles.
        do_txn(4'b0001, {NO_REQ, NO_REQ, NO_REQ, RWITM}, {32'h0, 32'h0, 32'h0, 32'h1000},
               {2'b00, FOUND, 2'b00, 2'b00}, 4'b0100, 3, 4'b0000, s);
        chk("t2_src", s, 0);

        // Requester's own FOUND/write-back lanes are ignored; one other write-back is not an error.
        do_txn(4'b0010, {NO_REQ, NO_REQ, RD, NO_REQ}, {32'h0, 32'h0, 32'hbeef0, 32'h0},
               {2'b00, 2'b00, FOUND, 2'b00}, 4'b0011, 1, 4'b0010, s);

        // Two other write-back lanes: error pulse during broadcast, write-back still runs.
        do_txn(4'b0010, {NO_REQ, NO_REQ, RD, NO_REQ}, {32'h0, 32'h0, 32'h80, 32'h0},
               '0, 4'b1001, 2, 4'b0010, s);

        // Core3 raises a request while core0 owns the bus.
        do_txn(4'b0001, {RD, NO_REQ, NO_REQ, RD}, {32'h300, 32'h0, 32'h0, 32'h100},
               '0, '0, 0, 4'b1001, s);
        chk("t4_first", s, 0);
        do_txn(4'b1001, {RD, NO_REQ, NO_REQ, RD}, {32'h300, 32'h0, 32'h0, 32'h100},
               '0, '0, 0, 4'b1001, s);
        chk("t4_core3", s, 3);

        // All cores requesting continuously from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rr  = 0;
        for (int i = 0; i < 5; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            do_txn(4'b1111, {RD, RD, RD, RD}, ra, '0, '0, 0, 4'b1111, s);
            chk("rr_order", s, i % N);
        end

        // Reset during write-back aborts the transaction and the pointer.
        req_valid = 4'b0010;
        req_type  = {NO_REQ, NO_REQ, RWITM, NO_REQ};
        req_addr  = {32'h0, 32'h0, 32'h200, 32'h0};
        step();
        chk("rst_bcast_src", bus_src, 1);
        snoop_wb = 4'b1000;
        step();
        snoop_wb = '0;
        chk("rst_in_wb", mem_wb_req, 1);
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_wb");
        step();
        chk("rst_no_done", done, 0);
        rr = 0;
        do_txn(4'b1001, {RD, NO_REQ, NO_REQ, RD}, {32'h30, 32'h0, 32'h0, 32'h10},
               '0, '0, 0, 4'b0000, s);
        chk("rst_rr_zero", s, 0);

`ifdef BUS_ARB_WB_TIMEOUT_EN
        // Write-back that is never acknowledged times out on its 16th cycle.
        req_valid = 4'b0001;
        req_type  = {NO_REQ, NO_REQ, NO_REQ, RD};
        req_addr  = {32'h0, 32'h0, 32'h0, 32'h500};
        step();
        req_valid = '0;
        snoop_wb  = 4'b0010;
        snoop_rsp = {2'b00, 2'b00, FOUND, 2'b00};
        step();
        snoop_wb  = '0;
        snoop_rsp = '0;
        for (int k = 1; k < 16; k++) begin
            chk("to_no_err", err, 0);
            chk("to_wb_req", mem_wb_req, 1);
            step();
        end
        #1;
        chk("to_err", err, 1);
        chk("to_wb_req16", mem_wb_req, 1);
        step();
        chk("to_done", done, 4'b0001);
        chk("to_found", done_found, 1);
        chk("to_done_wb_req", mem_wb_req, 0);
        chk("to_done_err", err, 0);
        rr = 1;
        step();
`endif

        for (int i = 0; i < 80; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            do_txn(N'($urandom), (2*N)'($urandom), ra, (2*N)'($urandom),
                   N'($urandom & $urandom), $urandom_range(0, 4), N'($urandom), s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
